// File: rtl/note_event_sync_fifo.sv
// note_event_sync_fifo
// Brings MIDI-side note events and key state into the OSC_CLK domain.
// Each note-on edge is queued in a small FIFO, and one queued event is
// released at every frame boundary (falling edge of n_xxxx_zero). The
// boundary is detected by sampling the synchronised marker, not by
// clocking on it.
//
// Optional build macro: NOTE_OFF_EN
//   Adds a note_off input and a reg_note_off output. A type bit is added
//   to each queued entry. If note_on and note_off edges arrive together,
//   note_on is queued first and note_off waits one cycle in a pending
//   register.
//
// Entry handshake: a push (synced note_on rising edge) is accepted
// whenever the queue is not full, or when a pop happens in the same
// cycle. Otherwise the event is dropped and overflow is set.

module note_event_sync_fifo #(
    parameter int VOICES      = 8,
    parameter int V_WIDTH     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int FD_WIDTH    = 2
) (
    input  logic                OSC_CLK,
    input  logic                reset,
    input  logic                n_xxxx_zero,
    input  logic                note_on,
`ifdef NOTE_OFF_EN
    input  logic                note_off,
`endif
    input  logic [V_WIDTH-1:0]  cur_key_adr,
    input  logic [7:0]          cur_key_val,
    input  logic [7:0]          cur_vel_on,
    input  logic [VOICES-1:0]   keys_on,
    input  logic                ovf_clr,
    output logic                reg_note_on,
`ifdef NOTE_OFF_EN
    output logic                reg_note_off,
`endif
    output logic [V_WIDTH-1:0]  reg_cur_key_adr,
    output logic [7:0]          reg_cur_key_val,
    output logic [7:0]          reg_cur_vel_on,
    output logic [VOICES-1:0]   reg_keys_on,
    output logic                frame_tick,
    output logic [FD_WIDTH:0]   fifo_level,
    output logic                overflow
);

`ifdef NOTE_OFF_EN
    localparam int ENTRY_W = V_WIDTH + 17;
`else
    localparam int ENTRY_W = V_WIDTH + 16;
`endif

    localparam logic [FD_WIDTH:0]   LEVEL_FULL = (FD_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [FD_WIDTH:0]   LEVEL_ONE  = (FD_WIDTH+1)'(1);
    localparam logic [FD_WIDTH-1:0] PTR_ONE    = FD_WIDTH'(1);

    // ------------------------------------------------------------------
    // Synchroniser chains, all of the same depth, so that data settles
    // together with the note_on edge that qualifies it.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] zero_sr;
    logic [SYNC_STAGES-1:0] on_sr;
`ifdef NOTE_OFF_EN
    logic [SYNC_STAGES-1:0] off_sr;
`endif
    logic [V_WIDTH-1:0]     adr_sr  [SYNC_STAGES];
    logic [7:0]             val_sr  [SYNC_STAGES];
    logic [7:0]             vel_sr  [SYNC_STAGES];
    logic [VOICES-1:0]      keys_sr [SYNC_STAGES];

    // Shift every asynchronous input through its register chain.
    // The frame marker resets to idle-high so reset release makes no tick.
    always_ff @(posedge OSC_CLK) begin
        if (reset) begin
            zero_sr <= '1;
            on_sr   <= '0;
`ifdef NOTE_OFF_EN
            off_sr  <= '0;
`endif
            for (int i = 0; i < SYNC_STAGES; i++) begin
                adr_sr[i]  <= '0;
                val_sr[i]  <= '0;
                vel_sr[i]  <= '0;
                keys_sr[i] <= '0;
            end
        end else begin
            zero_sr <= {zero_sr[SYNC_STAGES-2:0], n_xxxx_zero};
            on_sr   <= {on_sr[SYNC_STAGES-2:0], note_on};
`ifdef NOTE_OFF_EN
            off_sr  <= {off_sr[SYNC_STAGES-2:0], note_off};
`endif
            adr_sr[0]  <= cur_key_adr;
            val_sr[0]  <= cur_key_val;
            vel_sr[0]  <= cur_vel_on;
            keys_sr[0] <= keys_on;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                adr_sr[i]  <= adr_sr[i-1];
                val_sr[i]  <= val_sr[i-1];
                vel_sr[i]  <= vel_sr[i-1];
                keys_sr[i] <= keys_sr[i-1];
            end
        end
    end

    logic               zero_s;
    logic               on_s;
    logic [V_WIDTH-1:0] adr_s;
    logic [7:0]         val_s;
    logic [7:0]         vel_s;
    logic [VOICES-1:0]  keys_s;

    assign zero_s = zero_sr[SYNC_STAGES-1];
    assign on_s   = on_sr[SYNC_STAGES-1];
    assign adr_s  = adr_sr[SYNC_STAGES-1];
    assign val_s  = val_sr[SYNC_STAGES-1];
    assign vel_s  = vel_sr[SYNC_STAGES-1];
    assign keys_s = keys_sr[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge detection on the synced levels.
    // ------------------------------------------------------------------
    logic zero_d;
    logic on_d;
    logic on_edge;
`ifdef NOTE_OFF_EN
    logic off_s;
    logic off_d;
    logic off_edge;
    assign off_s    = off_sr[SYNC_STAGES-1];
    assign off_edge = off_s & ~off_d;
`endif

    assign on_edge = on_s & ~on_d;

    // Remember the previous synced levels. frame_tick is registered so it
    // is a clean one-cycle pulse for each falling frame marker.
    always_ff @(posedge OSC_CLK) begin
        if (reset) begin
            zero_d     <= 1'b1;
            on_d       <= 1'b0;
            frame_tick <= 1'b0;
`ifdef NOTE_OFF_EN
            off_d      <= 1'b0;
`endif
        end else begin
            zero_d     <= zero_s;
            on_d       <= on_s;
            frame_tick <= zero_d & ~zero_s;
`ifdef NOTE_OFF_EN
            off_d      <= off_s;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Write request selection.
    // ------------------------------------------------------------------
    logic               wr_req;
    logic [ENTRY_W-1:0] wr_data;
`ifdef NOTE_OFF_EN
    logic               pend_vld;
    logic [V_WIDTH-1:0] pend_adr;
    logic [7:0]         pend_val;
    logic               pend_set;
    logic               pend_clr;

    // note_on has priority; a coincident note_off is parked for one cycle.
    always_comb begin
        wr_req   = 1'b0;
        wr_data  = '0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        if (on_edge) begin
            wr_req   = 1'b1;
            wr_data  = {1'b0, adr_s, val_s, vel_s};
            pend_set = off_edge;
        end else if (pend_vld) begin
            wr_req   = 1'b1;
            wr_data  = {1'b1, pend_adr, pend_val, 8'd0};
            pend_clr = 1'b1;
        end else if (off_edge) begin
            wr_req   = 1'b1;
            wr_data  = {1'b1, adr_s, val_s, 8'd0};
        end
    end

    // Pending note_off holder; its data is captured at the edge cycle.
    always_ff @(posedge OSC_CLK) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_adr <= '0;
            pend_val <= '0;
        end else if (pend_set) begin
            pend_vld <= 1'b1;
            pend_adr <= adr_s;
            pend_val <= val_s;
        end else if (pend_clr) begin
            pend_vld <= 1'b0;
        end
    end
`else
    // Only note_on produces entries.
    always_comb begin
        wr_req  = on_edge;
        wr_data = {adr_s, val_s, vel_s};
    end
`endif

    // ------------------------------------------------------------------
    // Event queue.
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [FD_WIDTH-1:0] wr_ptr;
    logic [FD_WIDTH-1:0] rd_ptr;
    logic                empty;
    logic                full;
    logic                pop;
    logic                wr_ok;
    logic                drop;
    logic [ENTRY_W-1:0]  head;

    assign empty = (fifo_level == '0);
    assign full  = (fifo_level == LEVEL_FULL);
    assign pop   = frame_tick & ~empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign wr_ok = wr_req & (~full | pop);
    assign drop  = wr_req & full & ~pop;
    assign head  = mem[rd_ptr];

    // Storage array; no reset needed since level gates every read.
    always_ff @(posedge OSC_CLK) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and the sticky overflow flag.
    always_ff @(posedge OSC_CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-rate output registers, updated only on frame_tick.
    // ------------------------------------------------------------------
    // Snapshot keys and deliver the head entry; an empty queue drops the
    // note strobes and leaves the delivered values in place.
    always_ff @(posedge OSC_CLK) begin
        if (reset) begin
            reg_note_on     <= 1'b0;
`ifdef NOTE_OFF_EN
            reg_note_off    <= 1'b0;
`endif
            reg_cur_key_adr <= '0;
            reg_cur_key_val <= '0;
            reg_cur_vel_on  <= '0;
            reg_keys_on     <= '0;
        end else if (frame_tick) begin
            reg_keys_on <= keys_s;
            if (pop) begin
                reg_cur_key_adr <= head[16 +: V_WIDTH];
                reg_cur_key_val <= head[15:8];
`ifdef NOTE_OFF_EN
                if (head[ENTRY_W-1]) begin
                    reg_note_on  <= 1'b0;
                    reg_note_off <= 1'b1;
                end else begin
                    reg_note_on    <= 1'b1;
                    reg_note_off   <= 1'b0;
                    reg_cur_vel_on <= head[7:0];
                end
`else
                reg_note_on    <= 1'b1;
                reg_cur_vel_on <= head[7:0];
`endif
            end else begin
                reg_note_on  <= 1'b0;
`ifdef NOTE_OFF_EN
                reg_note_off <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_note_event_sync_fifo.sv
// tb_note_event_sync_fifo
// Drives note pulses and frame markers. The expected behaviour comes from an
// event-level model: a queue of pending events, popped once per frame.
module tb_note_event_sync_fifo;

  localparam int VOICES      = 8;
  localparam int V_WIDTH     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int FD_WIDTH    = 2;
  localparam int EW          = V_WIDTH + 17;

  logic                OSC_CLK = 1'b0;
  logic                reset;
  logic                n_xxxx_zero;
  logic                note_on;
  logic [V_WIDTH-1:0]  cur_key_adr;
  logic [7:0]          cur_key_val;
  logic [7:0]          cur_vel_on;
  logic [VOICES-1:0]   keys_on;
  logic                ovf_clr;
  logic                reg_note_on;
  logic [V_WIDTH-1:0]  reg_cur_key_adr;
  logic [7:0]          reg_cur_key_val;
  logic [7:0]          reg_cur_vel_on;
  logic [VOICES-1:0]   reg_keys_on;
  logic                frame_tick;
  logic [FD_WIDTH:0]   fifo_level;
  logic                overflow;
`ifdef NOTE_OFF_EN
  logic                note_off;
  logic                reg_note_off;
`endif

  note_event_sync_fifo #(
    .VOICES(VOICES), .V_WIDTH(V_WIDTH), .SYNC_STAGES(SYNC_STAGES),
    .FIFO_DEPTH(FIFO_DEPTH), .FD_WIDTH(FD_WIDTH)
  ) dut (
    .OSC_CLK(OSC_CLK), .reset(reset), .n_xxxx_zero(n_xxxx_zero),
    .note_on(note_on),
`ifdef NOTE_OFF_EN
    .note_off(note_off), .reg_note_off(reg_note_off),
`endif
    .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
    .cur_vel_on(cur_vel_on), .keys_on(keys_on), .ovf_clr(ovf_clr),
    .reg_note_on(reg_note_on), .reg_cur_key_adr(reg_cur_key_adr),
    .reg_cur_key_val(reg_cur_key_val), .reg_cur_vel_on(reg_cur_vel_on),
    .reg_keys_on(reg_keys_on), .frame_tick(frame_tick),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  // clock / reset block
  always #5 OSC_CLK = ~OSC_CLK;

  int vectors     = 0;
  int miscompares = 0;

  // scoreboard: entries {type, adr, val, vel}
  logic [EW-1:0]      exp_q[$];
  logic               e_on, e_off, e_ovf;
  logic [V_WIDTH-1:0] e_adr;
  logic [7:0]         e_val, e_vel;
  logic [VOICES-1:0]  e_keys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge OSC_CLK);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick_clk();
  endtask

  function automatic void model_clear();
    exp_q.delete();
    e_on = 0; e_off = 0; e_ovf = 0; e_adr = '0; e_val = '0; e_vel = '0; e_keys = '0;
  endfunction

  function automatic void model_push(input logic [EW-1:0] e);
    if (exp_q.size() == FIFO_DEPTH) e_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  function automatic void model_pop();
    logic [EW-1:0] e;
    e_keys = keys_on;
    if (exp_q.size() == 0) begin
      e_on = 1'b0; e_off = 1'b0;
    end else begin
      e = exp_q.pop_front();
      e_adr = e[16 +: V_WIDTH];
      e_val = e[15:8];
      if (e[EW-1]) begin
        e_on = 1'b0; e_off = 1'b1;
      end else begin
        e_on = 1'b1; e_off = 1'b0; e_vel = e[7:0];
      end
    end
  endfunction

  task automatic check_regs();
    check("reg_note_on", 32'(reg_note_on), 32'(e_on));
`ifdef NOTE_OFF_EN
    check("reg_note_off", 32'(reg_note_off), 32'(e_off));
`endif
    check("reg_cur_key_adr", 32'(reg_cur_key_adr), 32'(e_adr));
    check("reg_cur_key_val", 32'(reg_cur_key_val), 32'(e_val));
    check("reg_cur_vel_on", 32'(reg_cur_vel_on), 32'(e_vel));
    check("reg_keys_on", 32'(reg_keys_on), 32'(e_keys));
  endtask

  task automatic check_level();
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(e_ovf));
  endtask

  // driver: one note_on pulse with data held across it
  task automatic pulse(input logic [V_WIDTH-1:0] a, input logic [7:0] v, input logic [7:0] ve);
    cur_key_adr = a; cur_key_val = v; cur_vel_on = ve;
    tick_clk();
    note_on = 1'b1;
    step(2);
    note_on = 1'b0;
    step(SYNC_STAGES + 2);
    model_push({1'b0, a, v, ve});
    check_level();
  endtask

  // driver: one frame; optionally raise note_on so its push meets the pop
  task automatic do_frame(input bit with_push, input logic [V_WIDTH-1:0] a,
                          input logic [7:0] v, input logic [7:0] ve);
    int lat;
    lat = 0;
    if (with_push) begin
      cur_key_adr = a; cur_key_val = v; cur_vel_on = ve;
    end
    n_xxxx_zero = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick_clk();
      if (with_push && i == 1) note_on = 1'b1;
      if (frame_tick) begin
        lat = i;
        break;
      end
    end
    check("tick_latency", 32'(lat), 32'(SYNC_STAGES + 1));
    model_pop();
    tick_clk();
    check("tick_width", 32'(frame_tick), 32'd0);
    check_regs();
    if (with_push) model_push({1'b0, a, v, ve});
    note_on = 1'b0;
    n_xxxx_zero = 1'b1;
    step(SYNC_STAGES + 3);
    check_level();
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    tick_clk();
    ovf_clr = 1'b0;
    step(1);
    e_ovf = 1'b0;
    check_level();
  endtask

  initial begin
    int seen;
    int n;
    reset = 1'b1; n_xxxx_zero = 1'b1; note_on = 1'b0; ovf_clr = 1'b0;
    cur_key_adr = '0; cur_key_val = '0; cur_vel_on = '0; keys_on = '0;
`ifdef NOTE_OFF_EN
    note_off = 1'b0;
`endif
    model_clear();
    step(3);
    reset = 1'b0;
    step(1);
    check("reset_tick", 32'(frame_tick), 32'd0);
    check_regs();
    check_level();

    // single event, then an empty frame holding values
    keys_on = 8'hA5;
    pulse(3'd3, 8'd60, 8'd100);
    do_frame(0, '0, 8'd0, 8'd0);
    do_frame(0, '0, 8'd0, 8'd0);

    // keys change mid-frame is invisible until the next tick
    keys_on = 8'h3C;
    step(SYNC_STAGES + 2);
    check("keys_hold", 32'(reg_keys_on), 32'(e_keys));
    do_frame(0, '0, 8'd0, 8'd0);

    // three events in one frame, drained over four frames
    pulse(3'd1, 8'd60, 8'd10);
    pulse(3'd2, 8'd62, 8'd20);
    pulse(3'd4, 8'd64, 8'd30);
    repeat (4) do_frame(0, '0, 8'd0, 8'd0);

    // overflow on the fifth event, then clear
    for (int i = 0; i < 5; i++) pulse(3'(i), 8'(70 + i), 8'(40 + i));
    clear_ovf();

    // full + tick + push: slot freed, no overflow
    do_frame(1, 3'd5, 8'd90, 8'd80);
    repeat (4) do_frame(0, '0, 8'd0, 8'd0);
    // empty + tick + push: no bypass, delivered next frame
    do_frame(0, '0, 8'd0, 8'd0);
    do_frame(1, 3'd6, 8'd91, 8'd81);
    do_frame(0, '0, 8'd0, 8'd0);

    // reset mid-operation discards the queue
    pulse(3'd1, 8'd11, 8'd12);
    pulse(3'd2, 8'd13, 8'd14);
    reset = 1'b1;
    step(1);
    model_clear();
    check("reset_tick2", 32'(frame_tick), 32'd0);
    check_regs();
    check_level();
    step(1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < SYNC_STAGES + 4; i++) begin
      tick_clk();
      if (frame_tick) seen++;
    end
    check("no_tick_after_reset", 32'(seen), 32'd0);

`ifdef NOTE_OFF_EN
    // simultaneous note_on / note_off edges
    cur_key_adr = 3'd2; cur_key_val = 8'd60; cur_vel_on = 8'd90;
    tick_clk();
    note_on = 1'b1; note_off = 1'b1;
    step(2);
    note_on = 1'b0; note_off = 1'b0;
    step(SYNC_STAGES + 3);
    model_push({1'b0, 3'd2, 8'd60, 8'd90});
    model_push({1'b1, 3'd2, 8'd60, 8'd0});
    check_level();
    repeat (3) do_frame(0, '0, 8'd0, 8'd0);
`endif

    // randomized frames
    for (int f = 0; f < 14; f++) begin
      keys_on = 8'($urandom_range(0, 255));
      n = $urandom_range(0, 5);
      for (int p = 0; p < n; p++)
        pulse(3'($urandom_range(0, VOICES - 1)), 8'($urandom_range(0, 127)),
              8'($urandom_range(1, 127)));
      if (e_ovf && $urandom_range(0, 1) == 1) clear_ovf();
      do_frame($urandom_range(0, 1) == 1, 3'($urandom_range(0, VOICES - 1)),
               8'($urandom_range(0, 127)), 8'($urandom_range(1, 127)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
